// File: rtl/sprite_rom_arbiter.sv
// Shares one single-port synchronous sprite/background ROM among three pixel fetchers
// (0 = background, 1 = fireboy, 2 = icegirl) and routes returned bytes back by tag.
module sprite_rom_arbiter #(
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned BG_PRIO = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [2:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  output logic [2:0]        gnt,
  output logic [2:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned N_REQ = 3;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned N_STG = RD_LAT + 1;

  logic [PTR_W-1:0]            ptr_q, ptr_d;
  logic [2:0]                  gnt_c;
  logic [PTR_W-1:0]            cand_c;
  logic                        rr_hit_c;
  logic [ADDR_W-1:0]           win_addr_c;

  logic                        mem_en_q, mem_en_d;
  logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
  logic [N_STG-1:0][N_REQ-1:0] tag_q, tag_d;
  logic [2:0]                  rvalid_q, rvalid_d;
  logic [DATA_W-1:0]           rdata_q, rdata_d;
  logic                        busy_q, busy_d;

  function automatic logic req_at(input logic [2:0] r, input logic [PTR_W-1:0] i);
    case (i)
      2'd0:    req_at = r[0];
      2'd1:    req_at = r[1];
      2'd2:    req_at = r[2];
      default: req_at = 1'b0;
    endcase
  endfunction

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] i);
    case (i)
      2'd0:    wrap_inc = 2'd1;
      2'd1:    wrap_inc = 2'd2;
      default: wrap_inc = 2'd0;
    endcase
  endfunction

  // Arbitration: optional fixed background priority, round-robin scan from the pointer.
  always_comb begin
    gnt_c    = '0;
    ptr_d    = ptr_q;
    rr_hit_c = 1'b0;
    cand_c   = ptr_q;
    if (!Reset) begin
      if ((BG_PRIO != 0) && req[0]) begin
        gnt_c = 3'b001;
      end else begin
        for (int unsigned k = 0; k < N_REQ; k++) begin
          if (!rr_hit_c && req_at(req, cand_c) && !((BG_PRIO != 0) && (cand_c == 2'd0))) begin
            rr_hit_c = 1'b1;
            gnt_c    = 3'(3'b001 << cand_c);
            if (BG_PRIO != 0) begin
              // Pointer bounces between 1 and 2 when the background sits above the ring.
              ptr_d = (cand_c == 2'd1) ? 2'd2 : 2'd1;
            end else begin
              ptr_d = wrap_inc(cand_c);
            end
          end
          cand_c = wrap_inc(cand_c);
        end
      end
    end
  end

  always_comb begin
    case (gnt_c)
      3'b001:  win_addr_c = addr0;
      3'b010:  win_addr_c = addr1;
      3'b100:  win_addr_c = addr2;
      default: win_addr_c = '0;
    endcase
  end

  // Issue stage, tag pipeline and return register.
  always_comb begin
    mem_en_d   = |gnt_c;
    mem_addr_d = (|gnt_c) ? win_addr_c : mem_addr_q;
    tag_d      = '0;
    tag_d[0]   = gnt_c;
    for (int unsigned i = 1; i < N_STG; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    rvalid_d = tag_q[RD_LAT];
    rdata_d  = (|tag_q[RD_LAT]) ? mem_rdata : rdata_q;
    busy_d   = (|tag_d) || (|rvalid_d);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      tag_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      tag_q      <= tag_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt      = gnt_c;
  assign mem_en   = mem_en_q;
  assign mem_addr = mem_addr_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter: four builds (BG_PRIO 0/1, RD_LAT 1/2/4) share one
// stimulus stream; each has its own ROM, reference model and return monitor.
module tb_sprite_rom_arbiter;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned N_INST = 4;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic [2:0]        req = '0;
  logic [ADDR_W-1:0] addr0 = '0;
  logic [ADDR_W-1:0] addr1 = '0;
  logic [ADDR_W-1:0] addr2 = '0;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]        tag;
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  task automatic check(input int inst, input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL inst%0d %s at cycle %0d: got %0h want %0h", inst, name, cyc, got, exp);
    end
  endtask

  for (genvar g = 0; g < N_INST; g++) begin : g_inst
    localparam int unsigned BG  = 32'(g % 2);
    localparam int unsigned LAT = (g < 2) ? 2 : ((g == 2) ? 1 : 4);

    logic [2:0]        gnt, rvalid;
    logic [DATA_W-1:0] rdata, mem_rdata;
    logic              mem_en, busy;
    logic [ADDR_W-1:0] mem_addr;

    sprite_rom_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(LAT), .BG_PRIO(BG)
    ) u_dut (
      .Clk(Clk), .Reset(Reset), .req(req),
      .addr0(addr0), .addr1(addr1), .addr2(addr2),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy)
    );

    // ROM contents = address low byte; garbage on the bus when not enabled.
    logic [DATA_W-1:0] rom_pipe [LAT];
    always @(posedge Clk) begin
      for (int i = int'(LAT) - 1; i > 0; i--) rom_pipe[i] <= rom_pipe[i-1];
      rom_pipe[0] <= mem_en ? mem_addr[7:0] : 8'($urandom);
    end
    assign mem_rdata = rom_pipe[LAT-1];

    exp_t              sb[$];
    int                ptr = 0;
    int                last_gnt = -100;
    logic              exp_en = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [DATA_W-1:0] last_data = '0;
    bit                started = 1'b0;

    // Reference model: evaluates this cycle's inputs once they are stable.
    always @(posedge Clk) begin : model
      int w;
      int idx;
      logic [ADDR_W-1:0] a;
      #3;
      if (Reset) begin
        check(g, "gnt_in_reset", 32'(gnt), 32'd0);
        ptr = 0;
        sb.delete();
        last_gnt = -100;
        exp_en = 1'b0;
        last_data = '0;
        started = 1'b1;
      end else if (started) begin
        w = -1;
        if (BG == 1 && req[0]) begin
          w = 0;
        end else begin
          for (int k = 0; k < 3; k++) begin
            idx = (ptr + k) % 3;
            if (w < 0 && req[idx] && !(BG == 1 && idx == 0)) w = idx;
          end
          if (w >= 0) ptr = (BG == 1) ? ((w == 1) ? 2 : 1) : ((w + 1) % 3);
        end
        check(g, "gnt", 32'(gnt), (w < 0) ? 32'd0 : (32'd1 << w));
        exp_en = (w >= 0);
        if (w >= 0) begin
          a = (w == 0) ? addr0 : ((w == 1) ? addr1 : addr2);
          exp_addr = a;
          sb.push_back('{3'(1 << w), a[7:0], cyc + int'(LAT) + 2});
          last_gnt = cyc;
        end
      end
    end

    // Monitor: checks registered outputs against the scoreboard.
    always @(posedge Clk) begin : monitor
      exp_t e;
      int   d;
      #1;
      if (started) begin
        check(g, "mem_en", 32'(mem_en), 32'(exp_en));
        if (exp_en) check(g, "mem_addr", 32'(mem_addr), 32'(exp_addr));
        d = cyc - last_gnt;
        check(g, "busy", 32'(busy), 32'((d >= 1) && (d <= int'(LAT) + 2)));
        if (rvalid != 3'b000) begin
          if (sb.size() == 0) begin
            check(g, "rvalid_unexpected", 32'(rvalid), 32'd0);
          end else begin
            e = sb.pop_front();
            check(g, "rvalid_tag", 32'(rvalid), 32'(e.tag));
            check(g, "rdata", 32'(rdata), 32'(e.data));
            check(g, "rvalid_cycle", 32'(cyc), 32'(e.due));
            last_data = e.data;
          end
        end else begin
          check(g, "rdata_hold", 32'(rdata), 32'(last_data));
          if (sb.size() > 0 && sb[0].due <= cyc) begin
            check(g, "rvalid_missing", 32'(rvalid), 32'(sb[0].tag));
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic step(input logic rst, input logic [2:0] r, input logic [ADDR_W-1:0] a0,
                      input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
    @(posedge Clk);
    #2;
    Reset = rst;
    req   = r;
    addr0 = a0;
    addr1 = a1;
    addr2 = a2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, addr0, addr1, addr2);
  endtask

  initial begin
    step(1'b1, 3'b000, '0, '0, '0);
    step(1'b1, 3'b000, '0, '0, '0);

    // Single background read.
    step(1'b0, 3'b001, 19'h00010, '0, '0);
    idle(7);

    // All three requesting, then only the sprites.
    for (int i = 0; i < 4; i++) step(1'b0, 3'b111, 19'h00020, 19'h00120, 19'h00220);
    for (int i = 0; i < 3; i++) step(1'b0, 3'b110, 19'h00020, 19'h00130, 19'h00230);
    idle(7);

    // Back-to-back issue with ordered returns.
    step(1'b0, 3'b010, '0, 19'h00100, 19'h00200);
    step(1'b0, 3'b110, '0, 19'h00101, 19'h00200);
    step(1'b0, 3'b010, '0, 19'h00101, 19'h00200);
    idle(7);

    // Reset with reads in flight, then a fresh request.
    step(1'b0, 3'b110, '0, 19'h00140, 19'h00240);
    step(1'b0, 3'b110, '0, 19'h00141, 19'h00241);
    step(1'b1, 3'b000, '0, 19'h00141, 19'h00241);
    step(1'b0, 3'b110, '0, 19'h00150, 19'h00250);
    idle(8);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 64) == 0, 3'($urandom), ADDR_W'($urandom), ADDR_W'($urandom),
           ADDR_W'($urandom));
    end
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
